// File: rtl/fetch_unit_pkg.sv
// Shared constants, state encoding and slot type for the fetch front end.
package fetch_unit_pkg;

    localparam int ADDR_W = 32;
    localparam int INST_W = 32;

    localparam logic [ADDR_W-1:0] DEF_RESET_PC = 32'h0000_2000;
    localparam logic [INST_W-1:0] DEF_NOP_INST = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
        logic              valid;
    } dslot_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Redirect, icache and decode-register signals of the fetch unit.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    logic              stall_in;
    logic              pc_sel;
    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] icache_addr;
    logic              icache_re;
    logic [INST_W-1:0] icache_dout;
    logic              icache_stall;
    logic [INST_W-1:0] D_inst;
    logic [ADDR_W-1:0] D_pc;
    logic              D_valid;

    modport master (
        input  stall_in, pc_sel, redirect_pc, icache_dout, icache_stall,
        output icache_addr, icache_re, D_inst, D_pc, D_valid
    );

    modport slave (
        output stall_in, pc_sel, redirect_pc, icache_dout, icache_stall,
        input  icache_addr, icache_re, D_inst, D_pc, D_valid
    );
endinterface

// File: rtl/fetch_unit_hold.sv
// Hold register for the decode slot: tracks every unstalled cycle and replays it while stalled.
module fetch_hold_buf
    import fetch_unit_pkg::*;
#(
    parameter logic [INST_W-1:0] NOP_INST = DEF_NOP_INST
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   capture,
    input  logic   kill,
    input  logic   sel,
    input  dslot_t live,
    output dslot_t out
);
    dslot_t held;

    always_ff @(posedge clk) begin
        if (reset) begin
            held <= '{inst: NOP_INST, pc: '0, valid: 1'b0};
        end else if (capture) begin
            held <= live;
        end else if (kill) begin
            held.inst  <= NOP_INST;
            held.valid <= 1'b0;
        end
    end

    // A redirect at stall onset must not let the replayed slot look valid, even in that cycle.
    always_comb begin
        out = sel ? held : live;
        if (sel && kill) begin
            out.inst  = NOP_INST;
            out.valid = 1'b0;
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC, pending-redirect and kill tracking, one icache read per cycle.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [INST_W-1:0] NOP_INST = DEF_NOP_INST
) (
    input logic          clk,
    input logic          reset,
    fetch_unit_if.master bus
);
    fetch_state_e      state;
    logic [ADDR_W-1:0] last_pc, pend_pc, req_pc, addr, base_pc, target;
    logic              pend, kill, stall, onset, killed;
    dslot_t            live_slot, out_slot;

    assign stall   = bus.stall_in | bus.icache_stall;
    assign onset   = stall && (state == RUN);
    assign target  = bus.redirect_pc & ~32'h3;
    assign base_pc = pend ? pend_pc : last_pc + 32'd4;
    assign killed  = bus.pc_sel | pend | kill;

    always_comb begin
        addr = base_pc;
        unique case (state)
            BOOT:    addr = RESET_PC;
            RUN:     if (!stall && bus.pc_sel) addr = target;
            HOLD: begin
                if (stall)           addr = req_pc;
                else if (bus.pc_sel) addr = target;
            end
            default: addr = RESET_PC;
        endcase
    end

    always_comb begin
        live_slot = '{inst: NOP_INST, pc: '0, valid: 1'b0};
        if (state != BOOT) begin
            live_slot.inst  = killed ? NOP_INST : bus.icache_dout;
            live_slot.pc    = last_pc;
            live_slot.valid = !killed;
        end
    end

    fetch_hold_buf #(.NOP_INST(NOP_INST)) u_hold (
        .clk     (clk),
        .reset   (reset),
        .capture (!stall),
        .kill    (onset && bus.pc_sel),
        .sel     (stall && (state != BOOT)),
        .live    (live_slot),
        .out     (out_slot)
    );

    assign bus.icache_addr = addr;
    assign bus.icache_re   = ~reset;
    assign bus.D_inst      = out_slot.inst;
    assign bus.D_pc        = out_slot.pc;
    assign bus.D_valid     = out_slot.valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= BOOT;
            req_pc  <= RESET_PC;
            last_pc <= '0;
            pend    <= 1'b0;
            pend_pc <= '0;
            kill    <= 1'b1;
        end else begin
            unique case (state)
                BOOT: if (!stall) begin
                    state   <= RUN;
                    last_pc <= addr;
                    kill    <= 1'b0;
                end
                RUN, HOLD: begin
                    if (stall) begin
                        state <= HOLD;
                        if (state == RUN) req_pc <= addr;
                        // Latest redirect seen while stalled wins.
                        if (bus.pc_sel) begin
                            pend    <= 1'b1;
                            pend_pc <= target;
                        end
                    end else begin
                        state   <= RUN;
                        last_pc <= addr;
                        pend    <= 1'b0;
                        kill    <= 1'b0;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end
endmodule
